// File: rtl/bk_pkg.sv
// Shared types and helpers for the Brent-Kung adder family.
//   pg_t       : (generate, propagate) pair flowing through the prefix tree
//   bk_levels  : number of up-sweep levels for a given operand width
//   pg_combine : the associative prefix operator (hi o lo)
package bk_pkg;

  typedef struct packed {
    logic g;
    logic p;
  } pg_t;

  function automatic int bk_levels(input int width);
    return $clog2(width);
  endfunction

  // hi covers the more significant span, lo the adjacent less significant one.
  function automatic pg_t pg_combine(input pg_t hi, input pg_t lo);
    pg_t res;
    res.g = hi.g | (hi.p & lo.g);
    res.p = hi.p & lo.p;
    return res;
  endfunction

endpackage

// File: rtl/bk_prefix_tree.sv
// Combinational Brent-Kung carry network.
//   g_i, p_i : bit-level generate / propagate, WIDTH bits (power of two, >= 4)
//   c0_i     : carry into bit 0
//   carry_o  : carry_o[i] is the carry into bit i; carry_o[WIDTH] is the carry out
// Level 0 holds the bit signals, levels 1..LEVELS are the up-sweep and the
// remaining LEVELS-1 levels are the down-sweep. After the last level every
// column i holds the group (G,P) of span [i:0].
module bk_prefix_tree
  import bk_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] g_i,
  input  logic [WIDTH-1:0] p_i,
  input  logic             c0_i,
  output logic [WIDTH:0]   carry_o
);

  localparam int LEVELS = bk_levels(WIDTH);
  localparam int NLEV   = 2 * LEVELS - 1;

  for (genvar lv = 0; lv <= NLEV; lv++) begin : gStage
    logic [WIDTH-1:0] gRow;
    logic [WIDTH-1:0] pRow;

    if (lv == 0) begin : gLeaf
      assign gRow = g_i;
      assign pRow = p_i;
    end else begin : gInner
      for (genvar i = 0; i < WIDTH; i++) begin : gBit
        // Up-sweep level lv joins blocks of 2^lv; down-sweep level D fills
        // the midpoints of blocks of 2^D from the already-complete prefix.
        localparam bit UP   = (lv <= LEVELS);
        localparam int D    = UP ? lv : (2 * LEVELS - lv);
        localparam int SPAN = 1 << (D - 1);
        localparam bit NODE = UP ? (((i + 1) % (2 * SPAN)) == 0)
                                 : ((((i + 1) % (2 * SPAN)) == SPAN) && ((i + 1) > 2 * SPAN));
        if (NODE) begin : gNode
          pg_t hi;
          pg_t lo;
          pg_t res;
          assign hi  = {gStage[lv-1].gRow[i], gStage[lv-1].pRow[i]};
          assign lo  = {gStage[lv-1].gRow[i-SPAN], gStage[lv-1].pRow[i-SPAN]};
          assign res = pg_combine(hi, lo);
          assign gRow[i] = res.g;
          assign pRow[i] = res.p;
        end else begin : gPass
          assign gRow[i] = gStage[lv-1].gRow[i];
          assign pRow[i] = gStage[lv-1].pRow[i];
        end
      end
    end
  end

  // carry[i+1] = G[i:0] | P[i:0] & c0
  assign carry_o = {gStage[NLEV].gRow | (gStage[NLEV].pRow & {WIDTH{c0_i}}), c0_i};

endmodule

// File: rtl/bk_adder_pipe.sv
// Three-stage pipelined Brent-Kung adder/subtractor with valid/ready on both sides.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid / in_ready : input handshake; a, b, cin, sub, tag_in are the operation
//   out_valid/out_ready : output handshake; sum, cout, ovf, tag_out are the result
// sub=1 inverts b and the carry-in so that cin=0 yields a-b and cin=1 yields a-b-1;
// cout is then NOT-borrow. ovf is signed two's-complement overflow.
// S1 holds bit-level p/g, S2 holds p plus the resolved carry vector, S3 the outputs.
// A single global stall freezes every stage whenever the output is valid but
// not being taken, so bubbles travel as invalid stages and are never squeezed out.
module bk_adder_pipe
  import bk_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  input  logic [TAG_W-1:0] tag_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic [TAG_W-1:0] tag_out
);

  logic             advance;
  logic [WIDTH-1:0] bx;

  logic             v1_q, v2_q, v3_q;
  logic             v1_d, v2_d, v3_d;

  logic [WIDTH-1:0] s1P_q, s1G_q;
  logic             s1C0_q;
  logic [TAG_W-1:0] s1Tag_q;

  logic [WIDTH:0]   treeCarry;
  logic [WIDTH-1:0] s2P_q;
  logic [WIDTH:0]   s2Carry_q;
  logic [TAG_W-1:0] s2Tag_q;

  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic [TAG_W-1:0] tagOut_q, tagOut_d;

  assign advance  = !v3_q || out_ready;
  assign in_ready = advance;
  assign bx       = b ^ {WIDTH{sub}};

  bk_prefix_tree #(
    .WIDTH (WIDTH)
  ) uTree (
    .g_i     (s1G_q),
    .p_i     (s1P_q),
    .c0_i    (s1C0_q),
    .carry_o (treeCarry)
  );

  // Valid bits and output registers only change when the pipe moves; outputs
  // load only from a valid S2 so they keep the last result through bubbles.
  always_comb begin
    v1_d     = v1_q;
    v2_d     = v2_q;
    v3_d     = v3_q;
    sum_d    = sum_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    tagOut_d = tagOut_q;
    if (advance) begin
      v1_d = in_valid;
      v2_d = v1_q;
      v3_d = v2_q;
      if (v2_q) begin
        sum_d    = s2P_q ^ s2Carry_q[WIDTH-1:0];
        cout_d   = s2Carry_q[WIDTH];
        ovf_d    = s2Carry_q[WIDTH] ^ s2Carry_q[WIDTH-1];
        tagOut_d = s2Tag_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q     <= 1'b0;
      v2_q     <= 1'b0;
      v3_q     <= 1'b0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      tagOut_q <= '0;
    end else begin
      v1_q     <= v1_d;
      v2_q     <= v2_d;
      v3_q     <= v3_d;
      sum_q    <= sum_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
      tagOut_q <= tagOut_d;
    end
  end

  // Datapath stages carry no reset; their contents are qualified by the valid bits.
  always_ff @(posedge clk) begin
    if (advance) begin
      s1P_q     <= a ^ bx;
      s1G_q     <= a & bx;
      s1C0_q    <= cin ^ sub;
      s1Tag_q   <= tag_in;
      s2P_q     <= s1P_q;
      s2Carry_q <= treeCarry;
      s2Tag_q   <= s1Tag_q;
    end
  end

  assign out_valid = v3_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign tag_out   = tagOut_q;

endmodule

// File: tb/tb_bk_adder_pipe.sv
module tb_bk_adder_pipe;

  typedef struct packed {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    logic [3:0]  tag;
  } expT;

  typedef struct packed {
    logic [63:0] sum;
    logic        cout;
    logic        ovf;
    logic [3:0]  tag;
  } wideExpT;

  logic clk = 1'b0;
  logic rst = 1'b1;

  // 32-bit main instance
  logic        inValid, inReady, inCin, inSub, outValid, outReady, outCout, outOvf;
  logic [31:0] inA, inB, outSum;
  logic [3:0]  inTag, outTag;

  // 4-bit and 64-bit instances for the width sweep
  logic        in4Valid, in4Ready, cin4, sub4, out4Valid, cout4, ovf4;
  logic [3:0]  a4, b4, sum4, tag4, tagOut4;
  logic        in64Valid, in64Ready, cin64, sub64, out64Valid, cout64, ovf64;
  logic [63:0] a64, b64, sum64;
  logic [3:0]  tag64, tagOut64;
  logic        ready4 = 1'b1;
  logic        ready64 = 1'b1;

  int      checks = 0;
  int      errors = 0;
  int      stallCycles = 0;
  expT     expQ[$];
  wideExpT q4[$];
  wideExpT q64[$];
  logic    holdPending = 1'b0;
  expT     held;
  expT     popped;
  wideExpT popped4, popped64;

  always #5 clk = ~clk;

  bk_adder_pipe #(.WIDTH(32), .TAG_W(4)) dut (
    .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(inReady),
    .a(inA), .b(inB), .cin(inCin), .sub(inSub), .tag_in(inTag),
    .out_valid(outValid), .out_ready(outReady), .sum(outSum),
    .cout(outCout), .ovf(outOvf), .tag_out(outTag)
  );

  bk_adder_pipe #(.WIDTH(4), .TAG_W(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in4Valid), .in_ready(in4Ready),
    .a(a4), .b(b4), .cin(cin4), .sub(sub4), .tag_in(tag4),
    .out_valid(out4Valid), .out_ready(ready4), .sum(sum4),
    .cout(cout4), .ovf(ovf4), .tag_out(tagOut4)
  );

  bk_adder_pipe #(.WIDTH(64), .TAG_W(4)) dut64 (
    .clk(clk), .rst(rst), .in_valid(in64Valid), .in_ready(in64Ready),
    .a(a64), .b(b64), .cin(cin64), .sub(sub64), .tag_in(tag64),
    .out_valid(out64Valid), .out_ready(ready64), .sum(sum64),
    .cout(cout64), .ovf(ovf64), .tag_out(tagOut64)
  );

  task automatic checkOutput(input string name, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, observed, expected);
    end
  endtask

  // Arithmetic reference: a + (b ^ sub) + (cin ^ sub), overflow from operand signs.
  function automatic expT refModel(input logic [31:0] x, input logic [31:0] y,
                                   input logic ci, input logic s, input logic [3:0] t);
    logic [31:0] yx;
    logic [32:0] full;
    expT r;
    yx     = s ? ~y : y;
    full   = {1'b0, x} + {1'b0, yx} + {32'd0, ci ^ s};
    r.sum  = full[31:0];
    r.cout = full[32];
    r.ovf  = (x[31] == yx[31]) && (full[31] != x[31]);
    r.tag  = t;
    return r;
  endfunction

  // Called just after a rising edge; returns just after the edge that accepted the op.
  task automatic applyStimulus(input logic [31:0] opA, input logic [31:0] opB,
                               input logic opCin, input logic opSub, input logic [3:0] opTag,
                               input logic [31:0] expSum, input logic expCout, input logic expOvf);
    bit done = 0;
    inA = opA; inB = opB; inCin = opCin; inSub = opSub; inTag = opTag; inValid = 1'b1;
    for (int n = 0; n < 50 && !done; n++) begin
      @(negedge clk);
      if (inReady) begin
        expQ.push_back('{sum: expSum, cout: expCout, ovf: expOvf, tag: opTag});
        done = 1;
      end
      @(posedge clk);
      #1;
    end
    if (!done) checkOutput("accept_timeout", 0, 1);
  endtask

  task automatic driveRandom(input logic [3:0] t);
    logic [31:0] x, y;
    logic ci, s;
    expT e;
    x  = $urandom;
    y  = $urandom;
    ci = 1'($urandom_range(0, 1));
    s  = 1'($urandom_range(0, 1));
    e  = refModel(x, y, ci, s, t);
    applyStimulus(x, y, ci, s, t, e.sum, e.cout, e.ovf);
  endtask

  task automatic waitDrain();
    for (int n = 0; n < 50 && expQ.size() != 0; n++) @(posedge clk);
    #1;
    checkOutput("drain_empty", expQ.size(), 0);
  endtask

  // Scoreboard for the 32-bit instance, plus hold/stall checks under backpressure.
  always @(negedge clk) begin
    if (rst) begin
      holdPending = 1'b0;
    end else begin
      if (holdPending) begin
        checkOutput("hold_sum", outSum, held.sum);
        checkOutput("hold_cout", outCout, held.cout);
        checkOutput("hold_ovf", outOvf, held.ovf);
        checkOutput("hold_tag", outTag, held.tag);
      end
      if (outValid && !outReady) begin
        stallCycles++;
        checkOutput("stall_in_ready", inReady, 0);
        holdPending = 1'b1;
        held = '{sum: outSum, cout: outCout, ovf: outOvf, tag: outTag};
      end else begin
        holdPending = 1'b0;
      end
      if (outValid && outReady) begin
        if (expQ.size() == 0) begin
          checkOutput("extra_result", 1, 0);
        end else begin
          popped = expQ.pop_front();
          checkOutput("sum", outSum, popped.sum);
          checkOutput("cout", outCout, popped.cout);
          checkOutput("ovf", outOvf, popped.ovf);
          checkOutput("tag_out", outTag, popped.tag);
        end
      end
    end
  end

  // Scoreboards for the width-sweep instances (always ready).
  always @(negedge clk) begin
    if (!rst && out4Valid) begin
      if (q4.size() == 0) begin
        checkOutput("w4_extra", 1, 0);
      end else begin
        popped4 = q4.pop_front();
        checkOutput("w4_sum", {60'd0, sum4}, popped4.sum);
        checkOutput("w4_cout", cout4, popped4.cout);
        checkOutput("w4_ovf", ovf4, popped4.ovf);
        checkOutput("w4_tag", tagOut4, popped4.tag);
      end
    end
    if (!rst && out64Valid) begin
      if (q64.size() == 0) begin
        checkOutput("w64_extra", 1, 0);
      end else begin
        popped64 = q64.pop_front();
        checkOutput("w64_sum", sum64, popped64.sum);
        checkOutput("w64_cout", cout64, popped64.cout);
        checkOutput("w64_ovf", ovf64, popped64.ovf);
        checkOutput("w64_tag", tagOut64, popped64.tag);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    longint t0, t1;
    logic [3:0]  bx4;
    logic [4:0]  full5;
    logic [63:0] bx64;
    logic [64:0] full65;
    wideExpT w;

    inValid = 0; inA = 0; inB = 0; inCin = 0; inSub = 0; inTag = 0; outReady = 1;
    in4Valid = 0; a4 = 0; b4 = 0; cin4 = 0; sub4 = 0; tag4 = 0;
    in64Valid = 0; a64 = 0; b64 = 0; cin64 = 0; sub64 = 0; tag64 = 0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    @(negedge clk);
    checkOutput("rst_out_valid", outValid, 0);
    checkOutput("rst_in_ready", inReady, 1);
    checkOutput("rst_sum", outSum, 0);
    checkOutput("rst_cout", outCout, 0);
    checkOutput("rst_ovf", outOvf, 0);
    checkOutput("rst_tag", outTag, 0);
    @(posedge clk);
    #1;

    // All-ones plus one wraps with carry, result appears exactly 3 cycles later
    applyStimulus(32'hFFFF_FFFF, 32'h1, 0, 0, 4'd3, 32'h0, 1, 0);
    inValid = 0;
    @(negedge clk); checkOutput("latency_c1", outValid, 0);
    @(negedge clk); checkOutput("latency_c2", outValid, 0);
    @(negedge clk); checkOutput("latency_c3", outValid, 1);
    @(posedge clk);
    #1;

    // Directed vectors, hand-computed
    applyStimulus(32'h8000_0000, 32'h1, 0, 1, 4'd5, 32'h7FFF_FFFF, 1, 1);
    applyStimulus(32'h5, 32'h7, 0, 1, 4'd6, 32'hFFFF_FFFE, 0, 0);
    applyStimulus(32'hAAAA_AAAA, 32'h5555_5555, 1, 0, 4'd7, 32'h0, 1, 0);
    applyStimulus(32'hA, 32'h3, 1, 1, 4'd8, 32'h6, 1, 0);
    applyStimulus(32'h7FFF_FFFF, 32'h1, 0, 0, 4'd9, 32'h8000_0000, 0, 1);
    applyStimulus(32'h1234, 32'h1234, 0, 1, 4'd10, 32'h0, 1, 0);
    inValid = 0;
    waitDrain();

    // Back-to-back streaming, one accept per cycle
    t0 = $time;
    for (int i = 0; i < 100; i++) driveRandom(4'(i % 16));
    t1 = $time;
    inValid = 0;
    checkOutput("stream_cycles", (t1 - t0) / 10, 100);
    waitDrain();

    // Backpressure mid-burst
    stallCycles = 0;
    fork
      begin
        for (int i = 0; i < 40; i++) driveRandom(4'(i % 16));
        inValid = 0;
      end
      begin
        repeat (15) @(posedge clk);
        #1;
        outReady = 0;
        repeat (4) @(posedge clk);
        #1;
        outReady = 1;
      end
    join
    waitDrain();
    checkOutput("stall_cycles", stallCycles, 4);

    // Reset with three ops in flight; an input offered during reset is dropped
    outReady = 0;
    applyStimulus(32'h1, 32'h2, 0, 0, 4'd1, 32'h3, 0, 0);
    applyStimulus(32'h4, 32'h5, 0, 0, 4'd2, 32'h9, 0, 0);
    applyStimulus(32'h6, 32'h7, 0, 0, 4'd3, 32'hD, 0, 0);
    rst = 1; outReady = 1;
    inA = 32'h10; inB = 32'h20; inValid = 1;
    @(posedge clk);
    #1;
    rst = 0; inValid = 0;
    expQ.delete();
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      checkOutput("flush_out_valid", outValid, 0);
      checkOutput("flush_in_ready", inReady, 1);
    end
    @(posedge clk);
    #1;
    applyStimulus(32'h2, 32'h3, 0, 0, 4'd11, 32'h5, 0, 0);
    inValid = 0;
    waitDrain();

    // Width sweep: exhaustive 4-bit, random 64-bit
    for (int i = 0; i < 1024; i++) begin
      a4 = i[3:0]; b4 = i[7:4]; cin4 = i[8]; sub4 = i[9]; tag4 = i[7:4]; in4Valid = 1;
      if (i < 200) begin
        a64 = {$urandom, $urandom}; b64 = {$urandom, $urandom};
        cin64 = 1'($urandom_range(0, 1)); sub64 = 1'($urandom_range(0, 1));
        tag64 = 4'(i % 16); in64Valid = 1;
      end else begin
        in64Valid = 0;
      end
      @(negedge clk);
      if (in4Ready) begin
        bx4    = sub4 ? ~b4 : b4;
        full5  = {1'b0, a4} + {1'b0, bx4} + {4'd0, cin4 ^ sub4};
        w.sum  = {60'd0, full5[3:0]};
        w.cout = full5[4];
        w.ovf  = (a4[3] == bx4[3]) && (full5[3] != a4[3]);
        w.tag  = tag4;
        q4.push_back(w);
      end
      if (in64Valid && in64Ready) begin
        bx64   = sub64 ? ~b64 : b64;
        full65 = {1'b0, a64} + {1'b0, bx64} + {64'd0, cin64 ^ sub64};
        w.sum  = full65[63:0];
        w.cout = full65[64];
        w.ovf  = (a64[63] == bx64[63]) && (full65[63] != a64[63]);
        w.tag  = tag64;
        q64.push_back(w);
      end
      @(posedge clk);
      #1;
    end
    in4Valid = 0;
    in64Valid = 0;
    repeat (10) @(posedge clk);
    #1;
    checkOutput("w4_drain", q4.size(), 0);
    checkOutput("w64_drain", q64.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
